core_s1: RTL and testbench
==========================

# core_s1

Fetch stage of the LETC core.
- Owns the architectural fetch PC and issues in-order word fetches to instruction memory over a valid/ready request channel.
- Collects the in-order responses into a small credit-managed buffer and presents instruction/PC pairs to core_s2 with a valid/ready handshake.
- Consumes core_s2's branch_en/branch_target redirect by flushing buffered and in-flight wrong-path fetches.

## Interface
Parameters:
- RESET_PC, default 32'h0000_0000: fetch address after reset.
- FIFO_DEPTH, default 4: instruction buffer entries. Must be a power of two and ≥2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- branch_en  in  1  redirect request from core_s2
- branch_target  in  32  redirect address (word_t)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, always word aligned
- imem_rsp_valid  in  1  response valid; in order; no backpressure
- imem_rsp_data  in  32  fetched instruction word
- s2_valid  out  1  instruction available to core_s2
- s2_ready  in  1  core_s2 consumes
- s2_instruction  out  32  instruction word
- s2_pc  out  32  PC of s2_instruction
- s2_misaligned  out  1  entry is a misaligned-target fault, not an instruction

## Operation
State registers:
- fetch_pc: next request address.
- resp_pc: PC of the next expected response.
- outstanding: accepted requests not yet answered. Width $clog2(FIFO_DEPTH)+1.
- drop_cnt: responses still to be discarded. Same width.
- FIFO of {instruction, pc, misaligned}.
- FSM state: RUN, FAULT_PEND, FAULT_HOLD.

RUN:
- imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH) && !branch_en. Uses registered values, so every response is guaranteed a FIFO slot.
- On request accept (valid && ready): fetch_pc += 4 (mod 2^32, wraps to 0) and outstanding += 1.
- On imem_rsp_valid: outstanding -= 1.
  - If drop_cnt != 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {imem_rsp_data, resp_pc, 0} and resp_pc += 4.
- Pop on s2_valid && s2_ready. Push and pop may occur in the same cycle, including when the FIFO is full.
- s2_valid = FIFO non-empty && !branch_en.

Redirect (branch_en = 1), highest priority, any state:
- FIFO flushed (no pop handshake is counted).
- fetch_pc ← {branch_target[31:2], 2'b00} and resp_pc ← the same value.
- drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0). A same-cycle response is itself discarded.
- Next state is RUN, or FAULT_PEND if the target is misaligned (see Configuration).

Fault states:
- FAULT_PEND: no requests. Once outstanding == 0, push {32'h0000_0013, branch_target, 1} and go to FAULT_HOLD.
- FAULT_HOLD: no requests. The entry drains to core_s2; the state persists until the next redirect.

Responses arriving while drop_cnt == 0 and outstanding == 0 are a protocol violation (assertion).

## Timing
Reset values:
- imem_req_valid 0, imem_req_addr RESET_PC.
- s2_valid 0, s2_instruction 0, s2_pc 0, s2_misaligned 0.
- FIFO empty, counters 0, state RUN.

After reset:
- First request in the first cycle after rst_n deasserts.
- Asserting rst_n mid-operation discards all state immediately; in-flight memory responses must also be reset by the memory.

Latency and ordering:
- imem_rsp_valid earliest one cycle after request accept.
- s2_valid earliest one cycle after the response (registered FIFO output).
- Sustains one instruction per cycle for one-cycle memory at FIFO_DEPTH ≥ 4.
- Redirect takes effect on the next edge. New-target request is issued in the cycle after branch_en.

## Configuration
- LETC_S1_MISALIGN_TRAP_EN defined:
  - A redirect with branch_target[1:0] != 0 enters FAULT_PEND.
  - Exactly one s2_misaligned = 1 entry is delivered with s2_pc = unmasked branch_target.
- Undefined:
  - branch_target[1:0] is ignored (forced to 00).
  - The FSM never leaves RUN, and s2_misaligned is tied 0.

## Test plan
- Reset with RESET_PC = 32'h0000_1000, one-cycle memory, s2_ready = 1 → requests 0x1000, 0x1004, ...; s2_valid high every cycle from the third post-reset cycle; s2_pc increments by 4.
- Hold s2_ready = 0 → at most 4 requests accepted, FIFO full, imem_req_valid low; release s2_ready → entries drain in order, no loss or duplication.
- Three-cycle memory with 2 requests outstanding, branch_en with target 0x2000 → both stale responses dropped; next s2_pc = 0x2000.
- branch_en in the same cycle as imem_rsp_valid and s2_valid/s2_ready → no handshake counted to core_s2; that response discarded; drop_cnt = outstanding − 1.
- With LETC_S1_MISALIGN_TRAP_EN, target 0x3002 → single entry with s2_misaligned = 1, s2_pc = 0x3002, s2_instruction = 0x00000013; no further requests until the next branch_en. Without the macro, the next fetch address is 0x3000.
- fetch_pc = 0xFFFF_FFFC → next request address is 0x0000_0000.

Source files
------------

// File: rtl/core_s1.sv
// LETC fetch stage: PC ownership, in-order imem fetch, credit-managed instruction buffer, redirect flush.
// Define LETC_S1_MISALIGN_TRAP_EN to turn a misaligned redirect into a single fault entry for core_s2.
module core_s1 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        s2_valid,
  input  logic        s2_ready,
  output logic [31:0] s2_instruction,
  output logic [31:0] s2_pc,
  output logic        s2_misaligned
);

  // Handshakes: a transfer happens on a clock edge where valid && ready; valid never waits on ready,
  // and the response channel has no ready (a response is always accepted).
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, FAULT_PEND, FAULT_HOLD} state_t;

  state_t         state, state_next;
  logic [31:0]    fetch_pc, resp_pc;
  logic [CW-1:0]  outstanding, drop_cnt;
  logic [CW-1:0]  wr_ptr, rd_ptr, fifo_count;
  logic [31:0]    instr_mem [FIFO_DEPTH];
  logic [31:0]    pc_mem    [FIFO_DEPTH];
  logic [31:0]    target_aligned;
  logic [31:0]    push_instr, push_pc;
  logic           credit_ok, req_fire, rsp_drop, rsp_keep, push, pop, redirect_mis;

`ifdef LETC_S1_MISALIGN_TRAP_EN
  logic           mis_mem [FIFO_DEPTH];
  logic [31:0]    fault_pc;
  logic           push_mis;
  assign redirect_mis = |branch_target[1:0];
`else
  logic           unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];
  assign redirect_mis       = 1'b0;
`endif

  assign target_aligned = {branch_target[31:2], 2'b00};
  assign fifo_count     = wr_ptr - rd_ptr;

  // Credits are taken from registered counts, so every in-flight response already owns a slot.
  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
  assign imem_req_valid = rst_n && (state == RUN) && credit_ok && !branch_en;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);

  assign s2_valid       = (fifo_count != '0) && !branch_en;
  assign pop            = s2_valid && s2_ready;
  assign s2_instruction = instr_mem[rd_ptr[AW-1:0]];
  assign s2_pc          = pc_mem[rd_ptr[AW-1:0]];
`ifdef LETC_S1_MISALIGN_TRAP_EN
  assign s2_misaligned  = mis_mem[rd_ptr[AW-1:0]];
`else
  assign s2_misaligned  = 1'b0;
`endif

  always_comb begin
    push       = 1'b0;
    push_instr = imem_rsp_data;
    push_pc    = resp_pc;
`ifdef LETC_S1_MISALIGN_TRAP_EN
    push_mis   = 1'b0;
`endif
    if (!branch_en) begin
      if (rsp_keep) begin
        push = 1'b1;
`ifdef LETC_S1_MISALIGN_TRAP_EN
      end else if (state == FAULT_PEND && outstanding == '0) begin
        push       = 1'b1;
        push_instr = 32'h0000_0013;
        push_pc    = fault_pc;
        push_mis   = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    if (branch_en) begin
      state_next = redirect_mis ? FAULT_PEND : RUN;
    end else begin
      case (state)
        FAULT_PEND: if (outstanding == '0) state_next = FAULT_HOLD;
        default:    state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (branch_en) begin
        fetch_pc <= target_aligned;
        resp_pc  <= target_aligned;
        // A response landing in the redirect cycle is already wrong-path, so it is not counted.
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) resp_pc  <= resp_pc + 32'd4;
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef LETC_S1_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_pc <= '0;
    else if (branch_en) fault_pc <= branch_target;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
`ifdef LETC_S1_MISALIGN_TRAP_EN
        mis_mem[i]   <= 1'b0;
`endif
      end
    end else if (branch_en) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        instr_mem[wr_ptr[AW-1:0]] <= push_instr;
        pc_mem[wr_ptr[AW-1:0]]    <= push_pc;
`ifdef LETC_S1_MISALIGN_TRAP_EN
        mis_mem[wr_ptr[AW-1:0]]   <= push_mis;
`endif
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && drop_cnt == '0 && outstanding == '0));

endmodule

// File: tb/tb_core_s1.sv
// Bench for core_s1: in-order memory with random latency, random backpressure and redirects,
// checked against an architectural model of the expected fetch and delivery streams.
module tb_core_s1;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        branch_en = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        s2_valid;
  logic        s2_ready = 1'b0;
  logic [31:0] s2_instruction;
  logic [31:0] s2_pc;
  logic        s2_misaligned;

  core_s1 #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .branch_en(branch_en), .branch_target(branch_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_instruction(s2_instruction),
    .s2_pc(s2_pc), .s2_misaligned(s2_misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: expected addresses of accepted fetches still owed to core_s2, plus the memory.
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [31:0] exp_req_pc;
  logic [31:0] fault_pc_exp;
  logic [31:0] br_tgt;
  logic [31:0] last_del_pc, last_acc_addr;
  logic        last_req_valid, last_s2_valid;
  bit          fault_mode, br_done, saw_zero;
  int          cyc = 0, lat_min = 1, lat_max = 1, rdy_pct = 100, s2_pct = 100;
  int          br_mode = 0, delivered = 0, accepted = 0, fault_cnt = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; branch_en = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; s2_ready = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete(); exp_q.delete();
    exp_req_pc = RST_PC; fault_mode = 1'b0; br_mode = 0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_s2_valid", 32'(s2_valid), 32'd0);
    check("rst_s2_instr", s2_instruction, 32'd0);
    check("rst_s2_pc", s2_pc, 32'd0);
    check("rst_s2_mis", 32'(s2_misaligned), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // One clock: drive inputs after the falling edge, then sample and score what the next rising edge commits.
  task automatic step();
    int out_now;
    logic [31:0] pc;
    @(negedge clk);
    if (!rst_n) rst_n = 1'b1;
    branch_en      = 1'b0;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    s2_ready       = ($urandom_range(99) < s2_pct);
    out_now        = mem_addr_q.size();
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_fn(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    case (br_mode)
      1:       br_done = 1'b1;
      2:       br_done = (out_now == 2);
      3:       br_done = imem_rsp_valid && s2_valid && s2_ready;
      default: br_done = 1'b0;
    endcase
    if (br_done) begin
      branch_en = 1'b1; branch_target = br_tgt; br_mode = 0;
      #1;
    end
    last_req_valid = imem_req_valid;
    last_s2_valid  = s2_valid;
    if (br_done) begin
      check("branch_s2_valid", 32'(s2_valid), 32'd0);
      check("branch_req_valid", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      exp_req_pc = {br_tgt[31:2], 2'b00};
      fault_mode = 1'b0;
`ifdef LETC_S1_MISALIGN_TRAP_EN
      fault_mode   = (br_tgt[1:0] != 2'b00);
      fault_pc_exp = br_tgt;
      fault_cnt    = 0;
`endif
    end else begin
      if (fault_mode) check("fault_req_valid", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
        exp_q.push_back(exp_req_pc);
        if (imem_req_addr == 32'd0) saw_zero = 1'b1;
        last_acc_addr = imem_req_addr;
        exp_req_pc += 32'd4;
        accepted++;
      end
      if (s2_valid && s2_ready) begin
        delivered++;
        last_del_pc = s2_pc;
        if (fault_mode) begin
          check("fault_pc", s2_pc, fault_pc_exp);
          check("fault_instr", s2_instruction, 32'h0000_0013);
          check("fault_mis", 32'(s2_misaligned), 32'd1);
          fault_cnt++;
        end else if (exp_q.size() == 0) begin
          check("s2_unexpected", 32'(s2_valid), 32'd0);
        end else begin
          pc = exp_q.pop_front();
          check("s2_pc", s2_pc, pc);
          check("s2_instr", s2_instruction, mem_fn(pc));
          check("s2_mis", 32'(s2_misaligned), 32'd0);
        end
      end
    end
    cyc++;
  endtask

  task automatic wait_delivery(input string tag, input int budget);
    int  d0 = delivered;
    bit  ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (delivered > d0);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic fire_branch(input string tag, input int mode, input logic [31:0] tgt);
    br_mode = mode; br_tgt = tgt;
    for (int i = 0; i < 60 && br_mode != 0; i++) step();
    check(tag, 32'(br_mode), 32'd0);
    br_mode = 0;
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    do_reset();

    // Streaming from reset with a one-cycle memory.
    lat_min = 1; lat_max = 1; rdy_pct = 100; s2_pct = 100;
    step();
    check("first_req_valid", 32'(last_req_valid), 32'd1);
    step();
    check("s2_valid_early", 32'(last_s2_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("s2_valid_stream", 32'(last_s2_valid), 32'd1);
    end

    // Backpressure fills the buffer and stops fetching.
    s2_pct = 0;
    repeat (12) step();
    check("full_owed", 32'(exp_q.size()), 32'(DEPTH));
    check("full_req_valid", 32'(last_req_valid), 32'd0);
    check("full_s2_valid", 32'(last_s2_valid), 32'd1);
    s2_pct = 100;
    wait_delivery("drain_progress", 10);
    repeat (20) step();

    // Redirect with two requests in flight on a three-cycle memory.
    lat_min = 3; lat_max = 3;
    fire_branch("br3_fired", 2, 32'h0000_2000);
    wait_delivery("br3_progress", 40);
    check("br3_first_pc", last_del_pc, 32'h0000_2000);

    // Redirect coinciding with a response and a core_s2 handshake.
    lat_min = 2; lat_max = 2;
    repeat (10) step();
    fire_branch("br_rsp_fired", 3, 32'h0000_2400);
    wait_delivery("br_rsp_progress", 40);
    check("br_rsp_first_pc", last_del_pc, 32'h0000_2400);

    // Misaligned redirect target.
    lat_min = 1; lat_max = 1;
    repeat (5) step();
    fire_branch("mis_fired", 1, 32'h0000_3002);
    a0 = accepted;
`ifdef LETC_S1_MISALIGN_TRAP_EN
    repeat (20) step();
    check("fault_count", 32'(fault_cnt), 32'd1);
    check("fault_no_req", 32'(accepted - a0), 32'd0);
    fire_branch("fault_exit", 1, 32'h0000_3100);
    wait_delivery("fault_exit_progress", 40);
    check("fault_exit_pc", last_del_pc, 32'h0000_3100);
`else
    for (int i = 0; i < 10 && accepted == a0; i++) step();
    check("mis_first_req", last_acc_addr, 32'h0000_3000);
    wait_delivery("mis_progress", 40);
    check("mis_first_pc", last_del_pc, 32'h0000_3000);
`endif

    // Address wrap at the top of memory.
    saw_zero = 1'b0;
    fire_branch("wrap_fired", 1, 32'hFFFF_FFF8);
    repeat (20) step();
    check("wrap_to_zero", 32'(saw_zero), 32'd1);

    // Random latency, backpressure and redirects.
    lat_min = 1; lat_max = 4; rdy_pct = 70; s2_pct = 70;
    a0 = delivered;
    for (int i = 0; i < 1500; i++) begin
      if (br_mode == 0 && $urandom_range(99) < 3) begin
        br_mode = 1; br_tgt = $urandom;
      end
      step();
    end
    br_mode = 0;
    check("random_progress", 32'(delivered > a0 + 200), 32'd1);

    // Reset in the middle of traffic.
    do_reset();
    rdy_pct = 100; s2_pct = 100;
    wait_delivery("rst_mid_progress", 20);
    check("rst_mid_first_pc", last_del_pc, RST_PC);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
